// File: rtl/elelock_codeentry.sv
// Code-entry front end of the electronic lock: synchronises and debounces the
// 10-key pad, collects NDIGITS digits, checks them and manages the lockout.
module elelock_codeentry #(
  parameter int unsigned          NDIGITS  = 4,
  parameter logic [4*NDIGITS-1:0] PASSCODE = 16'h1234,
  parameter int unsigned          DEBOUNCE = 4,
  parameter int unsigned          TIMEOUT  = 1000,
  parameter int unsigned          MAX_FAIL = 3,
  parameter int unsigned          LOCK_CYC = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] tenkey,
  input  logic       close,
  output logic       key,
  output logic       fail,
  output logic       locked_out,
  output logic [3:0] digit_cnt
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int LW = $clog2(LOCK_CYC + 1);
  localparam int EW = 4 * NDIGITS;

  typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_CHECK, S_LOCKOUT} state_t;

  state_t         state;
  logic [9:0]     sync1, sync2, prev;
  logic [CW-1:0]  stab_cnt, stab_next;
  logic           armed, onehot, accept;
  logic [3:0]     digit;
  logic [EW-1:0]  entry;
  logic [EW+3:0]  entry_cat;
  logic [TW-1:0]  idle_cnt;
  logic [FW-1:0]  fail_cnt;
  logic [LW-1:0]  lock_cnt;

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    onehot    = (sync2 != '0) && ((sync2 & (sync2 - 10'd1)) == '0);
    stab_next = '0;
    if (onehot) begin
      if (sync2 != prev)                   stab_next = CW'(1);
      else if (stab_cnt == CW'(DEBOUNCE))  stab_next = stab_cnt;
      else                                 stab_next = stab_cnt + CW'(1);
    end
  end

  // One acceptance per press: armed drops on acceptance and only an all-zero
  // synced pad re-arms it; held keys during lockout also disarm.
  assign accept = armed && onehot && (stab_next == CW'(DEBOUNCE)) && (state != S_LOCKOUT);

  always_comb begin
    digit = '0;
    for (int i = 0; i < 10; i++) begin
      if (sync2[i]) digit = 4'(i);
    end
  end

  assign entry_cat = {entry, digit};

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync2    <= '0;
      prev     <= '0;
      stab_cnt <= '0;
      armed    <= 1'b0;
    end else begin
      sync1    <= tenkey;
      sync2    <= sync1;
      prev     <= sync2;
      stab_cnt <= stab_next;
      if (sync2 == '0)                          armed <= 1'b1;
      else if (accept || (state == S_LOCKOUT))  armed <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      entry      <= '0;
      digit_cnt  <= '0;
      idle_cnt   <= '0;
      fail_cnt   <= '0;
      lock_cnt   <= '0;
      key        <= 1'b0;
      fail       <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      key  <= 1'b0;
      fail <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept && !close) begin
            entry     <= entry_cat[EW-1:0];
            digit_cnt <= 4'd1;
            idle_cnt  <= '0;
            state     <= (NDIGITS == 1) ? S_CHECK : S_ENTRY;
          end
        end
        S_ENTRY: begin
          // close beats a simultaneous digit; a digit beats a simultaneous timeout
          if (close) begin
            entry     <= '0;
            digit_cnt <= '0;
            idle_cnt  <= '0;
            state     <= S_IDLE;
          end else if (accept) begin
            entry     <= entry_cat[EW-1:0];
            digit_cnt <= digit_cnt + 4'd1;
            idle_cnt  <= '0;
            if (digit_cnt + 4'd1 == 4'(NDIGITS)) state <= S_CHECK;
          end else if (idle_cnt == TW'(TIMEOUT - 1)) begin
            entry     <= '0;
            digit_cnt <= '0;
            idle_cnt  <= '0;
            state     <= S_IDLE;
          end else begin
            idle_cnt <= idle_cnt + TW'(1);
          end
        end
        S_CHECK: begin
          entry     <= '0;
          digit_cnt <= '0;
          state     <= S_IDLE;
          if (entry == PASSCODE) begin
            key      <= 1'b1;
            fail_cnt <= '0;
          end else begin
            fail <= 1'b1;
            if (fail_cnt >= FW'(MAX_FAIL - 1)) begin
              fail_cnt   <= '0;
              lock_cnt   <= '0;
              locked_out <= 1'b1;
              state      <= S_LOCKOUT;
            end else begin
              fail_cnt <= fail_cnt + FW'(1);
            end
          end
        end
        S_LOCKOUT: begin
          if (lock_cnt == LW'(LOCK_CYC - 1)) begin
            locked_out <= 1'b0;
            state      <= S_IDLE;
          end else begin
            lock_cnt <= lock_cnt + LW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_elelock_codeentry.sv
// Directed bench for elelock_codeentry: expected key/fail pulses are queued
// with their due cycle when the final digit is driven and matched on arrival.
module tb_elelock_codeentry;

  localparam int DEBOUNCE = 4;
  localparam int TIMEOUT  = 50;
  localparam int MAX_FAIL = 3;
  localparam int LOCK_CYC = 100;
  localparam int ACC      = 2 + DEBOUNCE;   // raw press -> digit accepted
  localparam int LAT      = ACC + 1;        // raw final press -> key/fail

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] tenkey = '0;
  logic       close = 1'b0;
  logic       key, fail, locked_out;
  logic [3:0] digit_cnt;

  typedef struct {
    bit is_key;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   last_pulse_cyc = 0;

  elelock_codeentry #(
    .NDIGITS (4),
    .PASSCODE(16'h1234),
    .DEBOUNCE(DEBOUNCE),
    .TIMEOUT (TIMEOUT),
    .MAX_FAIL(MAX_FAIL),
    .LOCK_CYC(LOCK_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tenkey    (tenkey),
    .close     (close),
    .key       (key),
    .fail      (fail),
    .locked_out(locked_out),
    .digit_cnt (digit_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse monitor: every key/fail pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && (key || fail)) begin
      check("key_fail_exclusive", 32'(key & fail), 32'(0));
      check("pulse_expected", 32'(exp_q.size() > 0), 32'(1));
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("pulse_is_key", 32'(key), 32'(mon_e.is_key));
        check("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic press(input int d, input int hold, input int gap, output int t0);
    tenkey    = '0;
    tenkey[d] = 1'b1;
    t0        = cyc;
    repeat (hold) @(negedge clk);
    tenkey = '0;
    repeat (gap) @(negedge clk);
  endtask

  // kind: 0 = no pulse expected, 1 = key, 2 = fail
  task automatic enter(input logic [15:0] code, input int kind);
    logic [3:0] d;
    exp_t       e;
    int         t0;
    for (int i = 0; i < 4; i++) begin
      d = code[4*(3-i) +: 4];
      if (i == 3 && kind != 0) begin
        e.is_key = (kind == 1);
        e.cyc    = cyc + LAT;
        last_pulse_cyc = e.cyc;
        exp_q.push_back(e);
      end
      press(int'(d), 10, 5, t0);
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check(tag, 32'(exp_q.size()), 32'(0));
  endtask

  task automatic pulse_close();
    close = 1'b1;
    @(negedge clk);
    close = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int fail_cyc;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_key", 32'(key), 32'(0));
    check("rst_fail", 32'(fail), 32'(0));
    check("rst_locked_out", 32'(locked_out), 32'(0));
    check("rst_digit_cnt", 32'(digit_cnt), 32'(0));
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_digit_cnt", 32'(digit_cnt), 32'(0));

    // Correct code, with exact acceptance timing on the first digit
    tenkey    = '0;
    tenkey[1] = 1'b1;
    t0        = cyc;
    wait_until(t0 + ACC - 1);
    check("accept_not_early", 32'(digit_cnt), 32'(0));
    @(negedge clk);
    check("accept_on_time", 32'(digit_cnt), 32'(1));
    wait_until(t0 + 10);
    tenkey = '0;
    repeat (5) @(negedge clk);
    press(2, 10, 5, t0);
    press(3, 10, 5, t0);
    check("three_digits", 32'(digit_cnt), 32'(3));
    mon_e.is_key = 1'b1;
    mon_e.cyc    = cyc + LAT;
    exp_q.push_back(mon_e);
    press(4, 10, 5, t0);
    drain("key_1234_seen");
    check("cnt_after_key", 32'(digit_cnt), 32'(0));

    // Bouncy key gives a single digit
    for (int i = 0; i < 8; i++) begin
      tenkey    = '0;
      tenkey[5] = (i % 2 == 0);
      @(negedge clk);
    end
    press(5, 10, 5, t0);
    check("bounce_one_digit", 32'(digit_cnt), 32'(1));
    pulse_close();
    check("close_after_bounce", 32'(digit_cnt), 32'(0));

    // Two keys together is not a press
    tenkey = 10'b00_0000_1100;
    repeat (10) @(negedge clk);
    tenkey = '0;
    repeat (5) @(negedge clk);
    check("multi_key_ignored", 32'(digit_cnt), 32'(0));

    // close aborts a partial entry
    press(1, 10, 5, t0);
    press(2, 10, 5, t0);
    check("partial_two", 32'(digit_cnt), 32'(2));
    pulse_close();
    check("close_aborts", 32'(digit_cnt), 32'(0));

    // Idle timeout discards a partial entry exactly TIMEOUT cycles after last digit
    press(1, 10, 5, t0);
    press(2, 10, 5, t0);
    wait_until(t0 + ACC + TIMEOUT - 1);
    check("timeout_not_early", 32'(digit_cnt), 32'(2));
    @(negedge clk);
    check("timeout_discard", 32'(digit_cnt), 32'(0));
    repeat (5) @(negedge clk);
    drain("no_pulse_close_timeout");

    // Three wrong codes -> lockout
    for (int i = 0; i < MAX_FAIL; i++) begin
      enter(16'h9999, 2);
      drain("fail_seen");
      check("locked_after_fail", 32'(locked_out), 32'(i == MAX_FAIL - 1));
    end
    fail_cyc = last_pulse_cyc;
    enter(16'h1234, 0);
    check("lockout_ignores_digits", 32'(digit_cnt), 32'(0));
    check("lockout_still_on", 32'(locked_out), 32'(1));
    wait_until(fail_cyc + LOCK_CYC - 1);
    check("lockout_last_cycle", 32'(locked_out), 32'(1));
    @(negedge clk);
    check("lockout_released", 32'(locked_out), 32'(0));
    repeat (3) @(negedge clk);
    enter(16'h1234, 1);
    drain("key_after_lockout");

    // Reset during lockout
    for (int i = 0; i < MAX_FAIL; i++) begin
      enter(16'h9999, 2);
      drain("fail_seen_2");
    end
    check("locked_again", 32'(locked_out), 32'(1));
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_lockout_locked", 32'(locked_out), 32'(0));
    check("rst_lockout_key", 32'(key), 32'(0));
    check("rst_lockout_fail", 32'(fail), 32'(0));
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Reset during a partial entry
    press(1, 10, 5, t0);
    press(2, 10, 5, t0);
    press(3, 10, 5, t0);
    check("partial_three", 32'(digit_cnt), 32'(3));
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_entry_cnt", 32'(digit_cnt), 32'(0));
    check("rst_entry_key", 32'(key), 32'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    enter(16'h1234, 1);
    drain("key_after_reset");
    check("final_locked_out", 32'(locked_out), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
